// File: rtl/cfa_pkg.sv
// cfa_pkg: constants and helpers shared by the CFA gradient datapath.
//   GRAD_TAPS  - number of neighbour taps feeding one gradient
//   SH_W       - width of one per-tap shift field
//   CFG_LEGACY - shift_cfg value giving the classic 1,2,4,2,1 weighting
//   grad_ow()  - output width for a given pixel width: 5 taps x weight 8
//                needs log2(40) < 6 extra bits above PW
package cfa_pkg;

    localparam int GRAD_TAPS = 5;
    localparam int SH_W      = 2;
    localparam logic [GRAD_TAPS*SH_W-1:0] CFG_LEGACY = 10'h064;

    function automatic int grad_ow(input int pw);
        return pw + 6;
    endfunction

endpackage

// File: rtl/cfa_absdiff.sv
// cfa_absdiff: combinational unsigned absolute difference |a - b|.
//   a, b : PW-bit unsigned operands
//   y    : PW-bit magnitude
// The difference is formed one bit wider than the operands so the sign is
// explicit and the magnitude is exact over the full unsigned range.
module cfa_absdiff #(
    parameter int PW = 12
) (
    input  logic [PW-1:0] a,
    input  logic [PW-1:0] b,
    output logic [PW-1:0] y
);

    logic [PW:0] diff;

    assign diff = {1'b0, a} - {1'b0, b};
    // Negating a negative (PW+1)-bit value always fits in PW bits.
    assign y    = diff[PW] ? PW'(-diff) : PW'(diff);

endmodule

// File: rtl/cfa_grad_pipe.sv
// cfa_grad_pipe: 3-stage pipelined 5-tap weighted absolute-gradient engine.
//   grad_abs = sum_i (|mean - e_i| << sh_i),  sh_i = shift_cfg[2i-1:2i-2]
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid / in_ready   - input sample handshake
//   e1..e5, mean          - PW-bit unsigned pixels
//   shift_cfg             - five 2-bit tap shifts, captured with the sample
//   tag_in                - sideband returned unchanged as tag_out
//   out_valid / out_ready - result handshake
//   grad_abs              - OW-bit weighted gradient sum
//   tag_out               - tag belonging to the current result
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// A producer holds valid and its data stable until the transfer; ready may
// depend on downstream ready but never on valid. While out_valid is high and
// out_ready is low, grad_abs and tag_out do not change.
module cfa_grad_pipe
    import cfa_pkg::*;
#(
    parameter int PW    = 12,
    parameter int TAG_W = 4,
    parameter int OW    = grad_ow(PW)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PW-1:0]             e1,
    input  logic [PW-1:0]             e2,
    input  logic [PW-1:0]             e3,
    input  logic [PW-1:0]             e4,
    input  logic [PW-1:0]             e5,
    input  logic [PW-1:0]             mean,
    input  logic [GRAD_TAPS*SH_W-1:0] shift_cfg,
    input  logic [TAG_W-1:0]          tag_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OW-1:0]             grad_abs,
    output logic [TAG_W-1:0]          tag_out
);

    // ---------------- stage occupancy and load enables ----------------
    logic v1, v2, v3;
    logic ld1, ld2, ld3;

    // A stage loads when it is empty or its contents move on this edge.
    // Chaining the enables back from out_ready compresses bubbles and lets
    // a full pipe accept and emit in the same cycle.
    assign ld3      = !v3 || out_ready;
    assign ld2      = !v2 || ld3;
    assign ld1      = !v1 || ld2;
    assign in_ready = ld1;
    assign out_valid = v3;

    // ---------------- S1: per-tap magnitudes ----------------
    logic [PW-1:0]   e_arr  [GRAD_TAPS];
    logic [PW-1:0]   mag    [GRAD_TAPS];
    logic [PW-1:0]   s1_mag [GRAD_TAPS];
    logic [SH_W-1:0] s1_sh  [GRAD_TAPS];
    logic [TAG_W-1:0] s1_tag;

    assign e_arr[0] = e1;
    assign e_arr[1] = e2;
    assign e_arr[2] = e3;
    assign e_arr[3] = e4;
    assign e_arr[4] = e5;

    for (genvar g = 0; g < GRAD_TAPS; g++) begin : g_tap
        cfa_absdiff #(.PW(PW)) u_absdiff (
            .a (mean),
            .b (e_arr[g]),
            .y (mag[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1     <= 1'b0;
            s1_tag <= '0;
            for (int i = 0; i < GRAD_TAPS; i++) begin
                s1_mag[i] <= '0;
                s1_sh[i]  <= '0;
            end
        end else if (ld1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_tag <= tag_in;
                for (int i = 0; i < GRAD_TAPS; i++) begin
                    s1_mag[i] <= mag[i];
                    s1_sh[i]  <= shift_cfg[i*SH_W +: SH_W];
                end
            end
        end
    end

    // ---------------- S2: weighting and partial sums ----------------
    logic [OW-1:0]    t [GRAD_TAPS];
    logic [OW-1:0]    p0, p1;
    logic [TAG_W-1:0] s2_tag;

    always_comb begin
        for (int i = 0; i < GRAD_TAPS; i++) begin
            t[i] = OW'(s1_mag[i]) << s1_sh[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2     <= 1'b0;
            p0     <= '0;
            p1     <= '0;
            s2_tag <= '0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                p0     <= t[0] + t[1] + t[2];
                p1     <= t[3] + t[4];
                s2_tag <= s1_tag;
            end
        end
    end

    // ---------------- S3: final sum ----------------
    // OW leaves headroom for 5 x 8 x max magnitude, so no carry is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3       <= 1'b0;
            grad_abs <= '0;
            tag_out  <= '0;
        end else if (ld3) begin
            v3 <= v2;
            if (v2) begin
                grad_abs <= p0 + p1;
                tag_out  <= s2_tag;
            end
        end
    end

endmodule
